// File: rtl/iob_axi_ram_responder.sv
// AXI4 slave backed by an internal synchronous RAM; one transaction at a time,
// INCR/FIXED bursts, byte-strobed writes, registered read data.
module iob_axi_ram_responder #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 14
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cke_i,
    input  logic [AXI_ID_W-1:0]       axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]     axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]      axi_awlen_i,
    input  logic [1:0]                axi_awburst_i,
    input  logic                      axi_awvalid_i,
    output logic                      axi_awready_o,
    input  logic [AXI_DATA_W-1:0]     axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0]   axi_wstrb_i,
    input  logic                      axi_wlast_i,
    input  logic                      axi_wvalid_i,
    output logic                      axi_wready_o,
    output logic [AXI_ID_W-1:0]       axi_bid_o,
    output logic [1:0]                axi_bresp_o,
    output logic                      axi_bvalid_o,
    input  logic                      axi_bready_i,
    input  logic [AXI_ID_W-1:0]       axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]     axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]      axi_arlen_i,
    input  logic [1:0]                axi_arburst_i,
    input  logic                      axi_arvalid_i,
    output logic                      axi_arready_o,
    output logic [AXI_ID_W-1:0]       axi_rid_o,
    output logic [AXI_DATA_W-1:0]     axi_rdata_o,
    output logic [1:0]                axi_rresp_o,
    output logic                      axi_rlast_o,
    output logic                      axi_rvalid_o,
    input  logic                      axi_rready_i
);
    localparam int NB    = AXI_DATA_W / 8;
    localparam int AL    = (NB > 1) ? $clog2(NB) : 1;
    localparam int DEPTH = 2 ** MEM_ADDR_W;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t                  state;
    logic                    prio_wr;
    logic                    fixed;
    logic                    mismatch;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [AXI_LEN_W-1:0]    len;
    logic [AXI_LEN_W-1:0]    cnt;
    logic [AXI_DATA_W-1:0]   mem [DEPTH];
    logic [AXI_DATA_W-1:0]   ram_q;

    logic                    grant_wr, idle;
    logic                    aw_fire, ar_fire, w_fire, r_fire, b_fire;
    logic                    last_beat, mm_next, rd_load;
    logic [AXI_LEN_W-1:0]    cnt_inc;
    logic [MEM_ADDR_W-1:0]   addr_adv, aw_word, ar_word, rd_sel;
    logic                    unused;

    assign grant_wr = axi_awvalid_i & (~axi_arvalid_i | prio_wr);
    assign idle     = (state == IDLE) & cke_i;
    assign axi_awready_o = idle & axi_awvalid_i & grant_wr;
    assign axi_arready_o = idle & axi_arvalid_i & ~grant_wr;

    assign aw_fire = axi_awready_o;
    assign ar_fire = axi_arready_o;
    assign w_fire  = cke_i & axi_wready_o & axi_wvalid_i;
    assign r_fire  = cke_i & axi_rvalid_o & axi_rready_i;
    assign b_fire  = cke_i & axi_bvalid_o & axi_bready_i;

    assign aw_word   = axi_awaddr_i[MEM_ADDR_W+AL-1:AL];
    assign ar_word   = axi_araddr_i[MEM_ADDR_W+AL-1:AL];
    assign addr_adv  = fixed ? addr : addr + 1'b1;
    assign cnt_inc   = cnt + 1'b1;
    assign last_beat = (cnt == len);
    assign mm_next   = mismatch | (axi_wlast_i != last_beat);

    // The RAM is read one beat ahead so the next beat is ready the cycle after a fire.
    assign rd_load = ~rst_i & (ar_fire | (r_fire & ~axi_rlast_o));
    assign rd_sel  = ar_fire ? ar_word : addr_adv;

    assign axi_rdata_o = axi_rvalid_o ? ram_q : '0;
    assign axi_rresp_o = 2'b00;
    assign unused      = ^{axi_awaddr_i, axi_araddr_i, axi_awburst_i[1], axi_arburst_i[1]};

    always_ff @(posedge clk_i) begin
        if (w_fire && !rst_i) begin
            for (int b = 0; b < NB; b++) begin
                if (axi_wstrb_i[b]) mem[addr][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
        if (rd_load) ram_q <= mem[rd_sel];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            prio_wr      <= 1'b1;
            fixed        <= 1'b0;
            mismatch     <= 1'b0;
            addr         <= '0;
            len          <= '0;
            cnt          <= '0;
            axi_wready_o <= 1'b0;
            axi_bvalid_o <= 1'b0;
            axi_bid_o    <= '0;
            axi_bresp_o  <= 2'b00;
            axi_rvalid_o <= 1'b0;
            axi_rid_o    <= '0;
            axi_rlast_o  <= 1'b0;
        end else if (cke_i) begin
            unique case (state)
                IDLE: begin
                    if (aw_fire) begin
                        state        <= WR_DATA;
                        axi_wready_o <= 1'b1;
                        axi_bid_o    <= axi_awid_i;
                        addr         <= aw_word;
                        len          <= axi_awlen_i;
                        cnt          <= '0;
                        fixed        <= (axi_awburst_i == 2'b00);
                        mismatch     <= 1'b0;
                        if (axi_arvalid_i) prio_wr <= 1'b0;
                    end else if (ar_fire) begin
                        state        <= RD_DATA;
                        axi_rvalid_o <= 1'b1;
                        axi_rid_o    <= axi_arid_i;
                        axi_rlast_o  <= (axi_arlen_i == '0);
                        addr         <= ar_word;
                        len          <= axi_arlen_i;
                        cnt          <= '0;
                        fixed        <= (axi_arburst_i == 2'b00);
                        if (axi_awvalid_i) prio_wr <= 1'b1;
                    end
                end
                WR_DATA: begin
                    // Burst length is taken from AWLEN; wlast only feeds the error flag.
                    if (w_fire) begin
                        addr     <= addr_adv;
                        cnt      <= cnt_inc;
                        mismatch <= mm_next;
                        if (last_beat) begin
                            state        <= WR_RESP;
                            axi_wready_o <= 1'b0;
                            axi_bvalid_o <= 1'b1;
                            axi_bresp_o  <= mm_next ? 2'b10 : 2'b00;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_fire) begin
                        state        <= IDLE;
                        axi_bvalid_o <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (r_fire) begin
                        if (axi_rlast_o) begin
                            state        <= IDLE;
                            axi_rvalid_o <= 1'b0;
                            axi_rlast_o  <= 1'b0;
                        end else begin
                            addr        <= addr_adv;
                            cnt         <= cnt_inc;
                            axi_rlast_o <= (cnt_inc == len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_axi_ram_responder.sv
// Randomized scoreboard bench for iob_axi_ram_responder with a word-array reference model.
module tb_iob_axi_ram_responder;
    localparam int MW    = 14;
    localparam int DEPTH = 1 << MW;

    logic clk = 1'b0;
    logic rst, cke;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;

    iob_axi_ram_responder dut (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awburst_i(awburst),
        .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arburst_i(arburst),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mdl   [DEPTH];
    bit          known [DEPTH];
    logic [31:0] wbuf  [256];
    logic [3:0]  sbuf  [256];

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [3:0] id; logic [31:0] data; bit chk; bit last; } r_t;
    b_t bq[$];
    r_t rq[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a B or R beat fires.
    b_t eb;
    r_t er;
    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (bq.size() == 0) check("unexpected_b", 1, 0);
            else begin
                eb = bq.pop_front();
                check("bid", bid, eb.id);
                check("bresp", bresp, eb.resp);
            end
        end
        if (!rst && rvalid && rready) begin
            if (rq.size() == 0) check("unexpected_r", 1, 0);
            else begin
                er = rq.pop_front();
                check("rid", rid, er.id);
                check("rlast", rlast, er.last);
                check("rresp", rresp, 2'b00);
                if (er.chk) check("rdata", rdata, er.data);
            end
        end
    end

    function automatic int wordof(input logic [31:0] a);
        return int'((a >> 2) & (DEPTH - 1));
    endfunction

    function automatic bit sig(input int w);
        case (w)
            0: return awready;
            1: return arready;
            default: return wready;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_sig(input int w, input string name);
        int n = 0;
        @(negedge clk);
        while (!sig(w)) begin
            n++;
            if (n > 100) begin check({name, "_timeout"}, 0, 1); return; end
            @(negedge clk);
        end
    endtask

    task automatic ar_expect(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst);
        int w = wordof(a);
        r_t e;
        for (int i = 0; i <= len; i++) begin
            e.id = id; e.data = mdl[w]; e.chk = known[w]; e.last = (i == len);
            rq.push_back(e);
            if (burst != 2'b00) w = (w + 1) % DEPTH;
        end
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst);
        awid = id; awaddr = a; awlen = 8'(len); awburst = burst;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst);
        arid = id; araddr = a; arlen = 8'(len); arburst = burst;
    endtask

    // Data phase + response: model updated and B expectation pushed at issue.
    task automatic w_phase(input logic [3:0] id, input logic [31:0] a, input int len,
                           input logic [1:0] burst, input int wlast_beat, input bit gaps);
        int w = wordof(a);
        bit mm = 0;
        b_t e;
        int n = 0;
        for (int i = 0; i <= len; i++) begin
            for (int b = 0; b < 4; b++)
                if (sbuf[i][b]) mdl[w][8*b +: 8] = wbuf[i][8*b +: 8];
            if (sbuf[i] == 4'hF) known[w] = 1;
            if ((i == wlast_beat) != (i == len)) mm = 1;
            if (burst != 2'b00) w = (w + 1) % DEPTH;
        end
        e.id = id; e.resp = mm ? 2'b10 : 2'b00;
        bq.push_back(e);
        for (int i = 0; i <= len; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin wvalid = 0; tick(); end
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == wlast_beat); wvalid = 1;
            wait_sig(2, "wready");
            tick();
        end
        wvalid = 0; wlast = 0;
        forever begin
            bready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bvalid && bready) break;
            n++;
            if (n > 100) begin check("b_timeout", 0, 1); break; end
            tick();
        end
        tick();
        bready = 0;
    endtask

    // mode 0: rready held high, 1: toggling 1010.., 2: random
    task automatic r_phase(input int mode, output int beats, output int span);
        int n = 0, first = 0;
        bit tg = 1;
        beats = 0; span = 0;
        forever begin
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? tg : 1'($urandom_range(0, 1));
            tg = ~tg;
            @(negedge clk);
            if (n == 0) check("rvalid_latency", rvalid, 1);
            if (rvalid && rready) begin
                if (beats == 0) first = cyc;
                beats++;
                if (rlast) begin span = cyc - first; break; end
            end
            n++;
            if (n > 2000) begin check("r_timeout", 0, 1); break; end
            tick();
        end
        tick();
        rready = 0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len,
                            input logic [1:0] burst, input int wlast_beat, input bit gaps);
        set_aw(id, a, len, burst); awvalid = 1;
        wait_sig(0, "awready");
        tick(); awvalid = 0;
        w_phase(id, a, len, burst, wlast_beat, gaps);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len,
                           input logic [1:0] burst, input int mode);
        int beats, span;
        ar_expect(id, a, len, burst);
        set_ar(id, a, len, burst); arvalid = 1;
        wait_sig(1, "arready");
        tick(); arvalid = 0;
        r_phase(mode, beats, span);
        check("r_beats", beats, len + 1);
        if (mode == 0) check("r_no_bubbles", span, len);
    endtask

    // AW and AR raised together; exp_wr says which one must win.
    task automatic race(input bit exp_wr, input logic [31:0] a);
        int beats, span;
        set_aw(4'h6, a, 0, 2'b01); set_ar(4'h9, a, 0, 2'b01);
        awvalid = 1; arvalid = 1;
        wbuf[0] = $urandom; sbuf[0] = 4'hF;
        @(negedge clk);
        check("race_awready", awready, exp_wr);
        check("race_arready", arready, !exp_wr);
        if (!exp_wr) ar_expect(4'h9, a, 0, 2'b01);
        tick();
        awvalid = 0; arvalid = 0;
        if (exp_wr) w_phase(4'h6, a, 0, 2'b01, 0, 0);
        else r_phase(0, beats, span);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; cke = 1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wlast = 0;
        set_aw(0, 0, 0, 0); set_ar(0, 0, 0, 0); wdata = 0; wstrb = 0;
        for (int i = 0; i < DEPTH; i++) known[i] = 0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs", {awready, arready, wready, bvalid, bid, bresp, rvalid, rid, rdata, rlast, rresp}, 0);
        tick(); rst = 0; tick();

        // single beat write then read
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(4'd3, 32'h10, 0, 2'b01, 0, 0);
        do_read(4'd5, 32'h10, 0, 2'b01, 0);

        // 8-beat INCR burst, read back with steady and toggling rready
        for (int i = 0; i < 8; i++) begin wbuf[i] = i; sbuf[i] = 4'hF; end
        do_write(4'd1, 32'h100, 7, 2'b01, 7, 0);
        do_read(4'd2, 32'h100, 7, 2'b01, 0);
        do_read(4'd2, 32'h100, 7, 2'b01, 1);

        // byte strobes
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        do_write(4'd4, 32'h200, 0, 2'b01, 0, 0);
        wbuf[0] = 32'h0; sbuf[0] = 4'h5;
        do_write(4'd4, 32'h200, 0, 2'b01, 0, 0);
        do_read(4'd4, 32'h200, 0, 2'b01, 0);
        check("strobe_model", mdl[wordof(32'h200)], 32'hFF00FF00);

        // FIXED burst lands on one word; INCR wraps from the top word to word 0
        for (int i = 0; i < 4; i++) begin wbuf[i] = i + 1; sbuf[i] = 4'hF; end
        do_write(4'd7, 32'h300, 3, 2'b00, 3, 0);
        do_read(4'd7, 32'h300, 0, 2'b01, 0);
        wbuf[0] = 32'hA5A5_0001; wbuf[1] = 32'h5A5A_0002;
        do_write(4'd8, (DEPTH - 1) * 4, 1, 2'b01, 1, 0);
        do_read(4'd8, 32'h0, 0, 2'b01, 0);
        do_read(4'd8, (DEPTH - 1) * 4, 1, 2'b10, 0);

        // wlast in the wrong place -> SLVERR, all four beats still taken
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0 + i; sbuf[i] = 4'hF; end
        do_write(4'd9, 32'h400, 3, 2'b01, 2, 0);
        check("wready_after_burst", wready, 0);
        do_write(4'd9, 32'h400, 3, 2'b01, 3, 0);
        do_read(4'd9, 32'h400, 3, 2'b01, 2);

        // clock enable low blocks a handshake
        cke = 0; set_aw(1, 32'h500, 0, 1); awvalid = 1;
        @(negedge clk);
        check("cke_awready", awready, 0);
        tick(); awvalid = 0; cke = 1;

        // AW/AR contention: write first, then strict alternation
        race(1, 32'h600); race(0, 32'h600); race(1, 32'h604); race(0, 32'h604); race(1, 32'h608);

        // reset in the middle of a read burst
        ar_expect(4'hA, 32'h100, 7, 2'b01);
        set_ar(4'hA, 32'h100, 7, 2'b01); arvalid = 1;
        wait_sig(1, "arready");
        tick(); arvalid = 0;
        tick(); tick();
        @(negedge clk);
        check("rvalid_before_reset", rvalid, 1);
        tick(); rst = 1; tick(); rst = 0;
        @(negedge clk);
        check("rvalid_after_reset", rvalid, 0);
        rq.delete();
        tick();
        race(1, 32'h60C);

        // randomized traffic over a small overlapping region
        for (int it = 0; it < 30; it++) begin
            int len = $urandom_range(0, 7);
            logic [31:0] a = 32'h1000 + 4 * $urandom_range(0, 63);
            logic [1:0] bu = 2'($urandom_range(0, 2));
            for (int i = 0; i <= len; i++) begin
                wbuf[i] = $urandom;
                sbuf[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            end
            do_write(4'($urandom), a, len, bu, len, 1);
            a = 32'h1000 + 4 * $urandom_range(0, 63);
            do_read(4'($urandom), a, $urandom_range(0, 7), 2'($urandom_range(0, 2)), 2);
        end

        check("b_queue_drained", bq.size(), 0);
        check("r_queue_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
